// File: rtl/dram_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dram_ctrl_pkg : state encodings and defaults for dram_ctrl       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package dram_ctrl_pkg;

    typedef enum logic [1:0] {
        DRAM_IDLE = 2'd0,
        DRAM_RD   = 2'd1,
        DRAM_WR   = 2'd2,
        DRAM_DONE = 2'd3
    } dram_state_e;

    localparam int DRAM_TIMEOUT   = 64;
    localparam int DRAM_WORD_LSB  = 2;

endpackage
`default_nettype wire

// File: rtl/dram_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dram_ctrl : mem-stage RAM request to handshaked SRAM, RMW stores |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module dram_ctrl
    import dram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = DRAM_TIMEOUT
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               ce_i,
    input  logic                               we_i,
    input  logic [ADDR_WIDTH-1:0]              addr_i,
    input  logic [DATA_WIDTH-1:0]              wdata_i,
    output logic [DATA_WIDTH-1:0]              rdata_o,
    output logic                               stall_o,
    output logic                               err_o,
    output logic                               sram_req_o,
    output logic                               sram_we_o,
    output logic [ADDR_WIDTH-DRAM_WORD_LSB-1:0] sram_addr_o,
    output logic [DATA_WIDTH-1:0]              sram_wdata_o,
    input  logic [DATA_WIDTH-1:0]              sram_rdata_i,
    input  logic                               sram_ack_i
);

    localparam int               CNT_W      = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] c_WAIT_MAX = CNT_W'(TIMEOUT - 1);

    dram_state_e                          state_q;
    logic [CNT_W-1:0]                     wait_cnt_q;
    logic [DATA_WIDTH-1:0]                rdata_q;
    logic [ADDR_WIDTH-DRAM_WORD_LSB-1:0]  addr_q;
    logic                                 err_q;
    logic                                 req_q;
    logic                                 we_q;
    logic                                 w_timeout;
    logic                                 w_unused_addr_lsb;

    assign w_timeout         = (wait_cnt_q == c_WAIT_MAX);
    assign w_unused_addr_lsb = ^addr_i[DRAM_WORD_LSB-1:0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= DRAM_IDLE;
            wait_cnt_q <= '0;
            rdata_q    <= '0;
            addr_q     <= '0;
            err_q      <= 1'b0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
        end else begin
            case (state_q)
                DRAM_IDLE: begin
                    if (ce_i) begin
                        addr_q     <= addr_i[ADDR_WIDTH-1:DRAM_WORD_LSB];
                        wait_cnt_q <= '0;
                        req_q      <= 1'b1;
                        we_q       <= 1'b0;
                        state_q    <= DRAM_RD;
                    end
                end
                DRAM_RD: begin
                    // An ack in the timeout cycle still completes the read normally.
                    if (sram_ack_i) begin
                        rdata_q    <= sram_rdata_i;
                        wait_cnt_q <= '0;
                        if (we_i) begin
                            we_q    <= 1'b1;
                            state_q <= DRAM_WR;
                        end else begin
                            req_q   <= 1'b0;
                            state_q <= DRAM_DONE;
                        end
                    end else if (w_timeout) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                        req_q   <= 1'b0;
                        state_q <= DRAM_DONE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                    end
                end
                DRAM_WR: begin
                    if (sram_ack_i) begin
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        state_q <= DRAM_DONE;
                    end else if (w_timeout) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        state_q <= DRAM_DONE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                    end
                end
                DRAM_DONE: begin
                    state_q <= DRAM_IDLE;
                end
                default: begin
                    req_q   <= 1'b0;
                    we_q    <= 1'b0;
                    state_q <= DRAM_IDLE;
                end
            endcase
        end
    end

    assign rdata_o      = rdata_q;
    assign err_o        = err_q;
    assign sram_req_o   = req_q;
    assign sram_we_o    = we_q;
    assign sram_addr_o  = addr_q;
    // Write data comes straight from mem, which has merged against rdata_o.
    assign sram_wdata_o = (state_q == DRAM_WR) ? wdata_i : '0;
    assign stall_o      = ((state_q == DRAM_IDLE) && ce_i)
                        || (state_q == DRAM_RD)
                        || (state_q == DRAM_WR);

endmodule
`default_nettype wire

// File: tb/tb_dram_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_dram_ctrl : table-driven scoreboard bench for dram_ctrl       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_dram_ctrl;

    localparam int TIMEOUT = 8;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        ce_i = 1'b0;
    logic        we_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic [31:0] rdata_o;
    logic        stall_o;
    logic        err_o;
    logic        sram_req_o;
    logic        sram_we_o;
    logic [29:0] sram_addr_o;
    logic [31:0] sram_wdata_o;
    logic [31:0] sram_rdata_i = '0;
    logic        sram_ack_i = 1'b0;

    int total = 0;
    int bad   = 0;

    dram_ctrl #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .TIMEOUT    (TIMEOUT)
    ) u_dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .ce_i         (ce_i),
        .we_i         (we_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .rdata_o      (rdata_o),
        .stall_o      (stall_o),
        .err_o        (err_o),
        .sram_req_o   (sram_req_o),
        .sram_we_o    (sram_we_o),
        .sram_addr_o  (sram_addr_o),
        .sram_wdata_o (sram_wdata_o),
        .sram_rdata_i (sram_rdata_i),
        .sram_ack_i   (sram_ack_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] rword;
        logic [31:0] wword;
        int          dly;        // read-phase wait cycles, -1 = never ack
        int          exp_stalls;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [29:0] waddr;
        logic [31:0] rdata;
        int          stalls;
        logic        err;
        int          wr_cycles;
        logic [31:0] wword;
    } exp_t;

    vec_t vecs[9];
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic do_access(input vec_t v);
        int          stalls = 0;
        int          req_cycles = 0;
        int          wr_cycles = 0;
        int          rd_cnt = 0;
        bit          rd_acked = 0;
        bit          addr_bad = 0;
        bit          wd_bad = 0;
        logic [31:0] wd_seen = '0;
        exp_t        e;

        e.waddr     = v.addr[31:2];
        e.rdata     = v.exp_rdata;
        e.stalls    = v.exp_stalls;
        e.err       = v.exp_err;
        e.wr_cycles = (v.we && v.dly >= 0) ? 1 : 0;
        e.wword     = v.wword;
        sb.push_back(e);

        ce_i = 1'b1; we_i = v.we; addr_i = v.addr; wdata_i = '0;
        sram_ack_i = 1'b0;
        #1;
        while (stall_o && stalls < 100) begin
            stalls++;
            if (sram_req_o) req_cycles++;
            if (sram_req_o && sram_addr_o != v.addr[31:2]) addr_bad = 1;
            if (!(sram_req_o && sram_we_o) && sram_wdata_o != 32'h0) wd_bad = 1;
            if (sram_req_o && !sram_we_o) begin
                if (v.dly >= 0 && rd_cnt == v.dly) begin
                    sram_ack_i   = 1'b1;
                    sram_rdata_i = v.rword;
                    rd_acked     = 1;
                end
                rd_cnt++;
            end else if (sram_req_o && sram_we_o) begin
                wr_cycles++;
                wd_seen    = sram_wdata_o;
                sram_ack_i = 1'b1;
            end
            @(posedge clk_i); #1;
            sram_ack_i   = 1'b0;
            sram_rdata_i = 32'hBAD0_BAD0;
            if (v.we && rd_acked) wdata_i = v.wword;
            #1;
        end
        chk("stall_bound", {31'h0, stall_o}, 32'h0);

        e = sb.pop_front();
        chk("stall_cycles", stalls, e.stalls);
        chk("req_cycles", req_cycles, e.stalls - 1);
        chk("wr_cycles", wr_cycles, e.wr_cycles);
        chk("sram_addr", {29'h0, addr_bad}, 32'h0);
        chk("wdata_gate", {29'h0, wd_bad}, 32'h0);
        if (e.wr_cycles > 0) chk("sram_wdata", wd_seen, e.wword);
        chk("done_addr", {2'b0, sram_addr_o}, {2'b0, e.waddr});
        chk("done_req", {31'h0, sram_req_o}, 32'h0);
        chk("done_rdata", rdata_o, e.rdata);
        chk("done_err", {31'h0, err_o}, {31'h0, e.err});

        // Spurious acks in DONE and then IDLE must be ignored.
        ce_i = 1'b0; sram_ack_i = 1'b1; sram_rdata_i = 32'h5A5A_0F0F;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        chk("idle_stall", {31'h0, stall_o}, 32'h0);
        chk("idle_req", {31'h0, sram_req_o}, 32'h0);
        chk("idle_rdata", rdata_o, e.rdata);
        sram_ack_i = 1'b0;
    endtask

    task automatic reset_mid_wr();
        ce_i = 1'b1; we_i = 1'b1; addr_i = 32'h0000_0300; wdata_i = '0;
        #1;
        @(posedge clk_i); #1;
        sram_ack_i = 1'b1; sram_rdata_i = 32'h7777_0000;
        @(posedge clk_i); #1;
        sram_ack_i = 1'b0; wdata_i = 32'h7777_00FF;
        #1;
        chk("rst_pre_we", {31'h0, sram_we_o}, 32'h1);
        rst_i = 1'b1; ce_i = 1'b0;
        #1;
        chk("rst_stall", {31'h0, stall_o}, 32'h0);
        chk("rst_req", {31'h0, sram_req_o}, 32'h0);
        chk("rst_we", {31'h0, sram_we_o}, 32'h0);
        chk("rst_wdata", sram_wdata_o, 32'h0);
        chk("rst_addr", {2'b0, sram_addr_o}, 32'h0);
        chk("rst_rdata", rdata_o, 32'h0);
        chk("rst_err", {31'h0, err_o}, 32'h0);
        we_i = 1'b0; wdata_i = '0;
        @(negedge clk_i); rst_i = 1'b0;
        @(posedge clk_i); #1;
    endtask

    initial begin
        //            we    addr          rword         wword         dly stalls rdata        err
        vecs[0] = '{1'b0, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0,        0,  2, 32'hDEAD_BEEF, 1'b0};
        vecs[1] = '{1'b1, 32'h0000_0200, 32'h1122_3344, 32'h1122_33AA, 0,  3, 32'h1122_3344, 1'b0};
        vecs[2] = '{1'b0, 32'h0000_03FC, 32'hCAFE_F00D, 32'h0,        5,  7, 32'hCAFE_F00D, 1'b0};
        vecs[3] = '{1'b0, 32'hFFFF_FFFC, 32'h0BAD_CAFE, 32'h0,        7,  9, 32'h0BAD_CAFE, 1'b0};
        vecs[4] = '{1'b0, 32'h0000_0010, 32'h1234_5678, 32'h0,        -1, 9, 32'h0,         1'b1};
        vecs[5] = '{1'b0, 32'h0000_0020, 32'hA5A5_5A5A, 32'h0,        0,  2, 32'hA5A5_5A5A, 1'b1};
        vecs[6] = '{1'b1, 32'h0000_0024, 32'h8765_4321, 32'h8765_43FF, 2,  5, 32'h8765_4321, 1'b1};
        vecs[7] = '{1'b1, 32'h0000_0028, 32'h0000_0001, 32'h0000_0002, -1, 9, 32'h0,         1'b1};
        vecs[8] = '{1'b0, 32'h0000_0040, 32'h1357_9BDF, 32'h0,        1,  3, 32'h1357_9BDF, 1'b0};

        #3;
        chk("reset_stall", {31'h0, stall_o}, 32'h0);
        chk("reset_req", {31'h0, sram_req_o}, 32'h0);
        chk("reset_we", {31'h0, sram_we_o}, 32'h0);
        chk("reset_addr", {2'b0, sram_addr_o}, 32'h0);
        chk("reset_wdata", sram_wdata_o, 32'h0);
        chk("reset_rdata", rdata_o, 32'h0);
        chk("reset_err", {31'h0, err_o}, 32'h0);
        #9 rst_i = 1'b0;
        @(posedge clk_i); #1;

        for (int i = 0; i < 9; i++) begin
            if (i == 8) reset_mid_wr();
            do_access(vecs[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
